// File: rtl/rgb_hsv_pkg.sv
// Shared types and constants for the RGB-to-HSV converter and its serial divider.
package rgb_hsv_pkg;

  typedef enum logic [2:0] {IDLE, PREP, DIV_S, DIV_H, HOLD} state_e;
  typedef enum logic [1:0] {SEC_R, SEC_G, SEC_B} sector_e;

  localparam int DIV_BITS = 15;
  localparam int LATENCY  = 32;

  localparam logic [8:0] HUE_60  = 9'd60;
  localparam logic [8:0] HUE_120 = 9'd120;
  localparam logic [8:0] HUE_240 = 9'd240;
  localparam logic [8:0] HUE_360 = 9'd360;
  localparam logic [6:0] S_SCALE = 7'd127;

  // hsv word layout: {H[8:0], S[6:0], V[7:0]}
  localparam int H_MSB = 23;
  localparam int H_LSB = 15;
  localparam int S_MSB = 14;
  localparam int S_LSB = 8;
  localparam int V_MSB = 7;
  localparam int V_LSB = 0;

endpackage

// File: rtl/rgb_hsv_div_seq.sv
// Restoring serial divider: 15-bit dividend / 8-bit divisor, one quotient bit per
// clock MSB first. The first bit is produced on the start edge, so 15 edges total.
module div_seq
  import rgb_hsv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DIV_BITS-1:0] dividend,
  input  logic [7:0]          divisor,
  output logic [DIV_BITS-1:0] quotient,
  output logic                done
);

  logic [7:0]          rem_q, rem_d;
  logic [7:0]          dvs_q, dvs_d;
  logic [DIV_BITS-1:0] quo_q, quo_d;
  logic [3:0]          cnt_q, cnt_d;

  logic [7:0]          src_rem, src_dvs;
  logic [DIV_BITS-1:0] src_quo;
  logic [8:0]          shifted;

  always_comb begin
    src_rem = start ? 8'd0 : rem_q;
    src_quo = start ? dividend : quo_q;
    src_dvs = start ? divisor : dvs_q;
    shifted = {src_rem, src_quo[DIV_BITS-1]};
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    if (start || cnt_q != 4'd0) begin
      dvs_d = src_dvs;
      // quo shifts the dividend out at the top while quotient bits enter at the bottom
      if (shifted >= {1'b0, src_dvs}) begin
        rem_d = 8'(shifted - {1'b0, src_dvs});
        quo_d = {src_quo[DIV_BITS-2:0], 1'b1};
      end else begin
        rem_d = shifted[7:0];
        quo_d = {src_quo[DIV_BITS-2:0], 1'b0};
      end
      cnt_d = start ? 4'(DIV_BITS - 1) : cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient = quo_q;
  assign done     = (cnt_q == 4'd0);

endmodule

// File: rtl/rgb_hsv.sv
// RGB-to-HSV converter: one pixel in flight, fixed input-to-output latency, shared
// serial divider used first for saturation then for hue.
//   state | meaning
//   IDLE  | ready for a pixel
//   PREP  | max/min/delta/sector, start S division
//   DIV_S | S division running, then start H division
//   DIV_H | H division, wait for latency terminal count
//   HOLD  | result presented until consumer takes it
module rgb_hsv #(
  parameter int LATENCY = rgb_hsv_pkg::LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] rgb,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] hsv,
  output logic        out_valid,
  input  logic        out_ready
);
  import rgb_hsv_pkg::*;

  state_e      state_q, state_d;
  sector_e     sec_q, sec_d, sec_c;
  logic [23:0] rgb_q, rgb_d, hsv_q, hsv_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  max_q, max_d, delta_q, delta_d, num_q, num_d;
  logic        neg_q, neg_d;
  logic [6:0]  s_q, s_d;
  logic [5:0]  lat_q, lat_d;

  logic [7:0]          r, g, b, mx, mn, na, nb;
  logic                div_start, div_done;
  logic [DIV_BITS-1:0] div_dividend, div_quo;
  logic [7:0]          div_divisor;
  logic [DIV_BITS-1:0] q_h, base, hue_raw;

  div_seq u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quo),
    .done     (div_done)
  );

  always_comb begin
    r = rgb_q[23:16];
    g = rgb_q[15:8];
    b = rgb_q[7:0];
    if (r >= g && r >= b) begin
      sec_c = SEC_R; mx = r; na = g; nb = b;
    end else if (g >= b) begin
      sec_c = SEC_G; mx = g; na = b; nb = r;
    end else begin
      sec_c = SEC_B; mx = b; na = r; nb = g;
    end
    mn = (r <= g && r <= b) ? r : ((g <= b) ? g : b);

    q_h = (delta_q == 8'd0) ? '0 : div_quo;
    case (sec_q)
      SEC_R:   base = '0;
      SEC_G:   base = DIV_BITS'(HUE_120);
      default: base = DIV_BITS'(HUE_240);
    endcase
    if (!neg_q)         hue_raw = base + q_h;
    else if (base >= q_h) hue_raw = base - q_h;
    else                hue_raw = base + DIV_BITS'(HUE_360) - q_h;

    state_d      = state_q;
    sec_d        = sec_q;
    rgb_d        = rgb_q;
    hsv_d        = hsv_q;
    out_valid_d  = out_valid_q;
    max_d        = max_q;
    delta_d      = delta_q;
    num_d        = num_q;
    neg_d        = neg_q;
    s_d          = s_q;
    lat_d        = lat_q;
    div_start    = 1'b0;
    div_dividend = '0;
    div_divisor  = '0;

    if ((state_q == PREP || state_q == DIV_S || state_q == DIV_H) && lat_q != 6'd0)
      lat_d = lat_q - 6'd1;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rgb_d   = rgb;
          lat_d   = 6'(LATENCY - 1);
          state_d = PREP;
        end
      end
      PREP: begin
        max_d        = mx;
        delta_d      = mx - mn;
        sec_d        = sec_c;
        neg_d        = na < nb;
        num_d        = (na < nb) ? nb - na : na - nb;
        div_start    = 1'b1;
        div_dividend = DIV_BITS'(mx - mn) * DIV_BITS'(S_SCALE);
        div_divisor  = mx;
        state_d      = DIV_S;
      end
      DIV_S: begin
        if (div_done) begin
          s_d          = (max_q == 8'd0) ? 7'd0 : div_quo[6:0];
          div_start    = 1'b1;
          div_dividend = DIV_BITS'(num_q) * DIV_BITS'(HUE_60);
          div_divisor  = delta_q;
          state_d      = DIV_H;
        end
      end
      DIV_H: begin
        // the latency timer, not the divider, decides when the result appears
        if (lat_q == 6'd0) begin
          hsv_d[H_MSB:H_LSB] = (hue_raw == DIV_BITS'(HUE_360)) ? 9'd0 : hue_raw[8:0];
          hsv_d[S_MSB:S_LSB] = s_q;
          hsv_d[V_MSB:V_LSB] = max_q;
          out_valid_d        = 1'b1;
          state_d            = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sec_q       <= SEC_R;
      rgb_q       <= '0;
      hsv_q       <= '0;
      out_valid_q <= 1'b0;
      max_q       <= '0;
      delta_q     <= '0;
      num_q       <= '0;
      neg_q       <= 1'b0;
      s_q         <= '0;
      lat_q       <= '0;
    end else begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      rgb_q       <= rgb_d;
      hsv_q       <= hsv_d;
      out_valid_q <= out_valid_d;
      max_q       <= max_d;
      delta_q     <= delta_d;
      num_q       <= num_d;
      neg_q       <= neg_d;
      s_q         <= s_d;
      lat_q       <= lat_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign hsv       = hsv_q;
  assign out_valid = out_valid_q;

endmodule
